// File: rtl/npu_spm_defines.sv
// Shared sizing constants, field typedefs and FSM encodings for the SPM bank request path.
package npu_spm_defines;

    localparam int SM_PROCESSING_ELEMENTS = 16;
    localparam int SM_MEMORY_BANKS        = 16;
    localparam int SM_ENTRIES             = 1024;
    localparam int SM_DATA_WIDTH          = 32;

    localparam int SM_BANK_W   = $clog2(SM_MEMORY_BANKS);
    localparam int SM_OFFSET_W = $clog2(SM_ENTRIES);
    localparam int SM_ADDR_W   = SM_BANK_W + SM_OFFSET_W;
    localparam int SM_BYTES    = SM_DATA_WIDTH / 8;

    typedef logic [SM_ADDR_W-1:0]     spm_lane_addr_t;
    typedef logic [SM_BANK_W-1:0]     spm_bank_idx_t;
    typedef logic [SM_OFFSET_W-1:0]   spm_offset_t;
    typedef logic [SM_DATA_WIDTH-1:0] spm_data_t;
    typedef logic [SM_BYTES-1:0]      spm_byte_mask_t;

    localparam logic [1:0] SPM_IDLE  = 2'd0;
    localparam logic [1:0] SPM_ISSUE = 2'd1;
    localparam logic [1:0] SPM_DRAIN = 2'd2;
    localparam logic [1:0] SPM_RESP  = 2'd3;

endpackage

// File: rtl/spm_bank_arbiter.sv
// Per-bank conflict resolution: lowest pending lane wins its bank; loads broadcast to
// every pending lane on the winner's offset, stores serve the winner alone.
module spm_bank_arbiter
    import npu_spm_defines::*;
#(
    parameter int LANES    = SM_PROCESSING_ELEMENTS,
    parameter int BANKS    = SM_MEMORY_BANKS,
    parameter int OFFSET_W = SM_OFFSET_W,
    parameter int BANK_W   = $clog2(BANKS),
    parameter int LANE_W   = $clog2(LANES)
) (
    input  logic [LANES-1:0]                i_pending,
    input  logic [LANES-1:0][BANK_W-1:0]    i_lane_bank,
    input  logic [LANES-1:0][OFFSET_W-1:0]  i_lane_offset,
    input  logic                            i_is_store,
    output logic [BANKS-1:0]                o_winner_valid,
    output logic [BANKS-1:0][LANE_W-1:0]    o_winner,
    output logic [BANKS-1:0][LANES-1:0]     o_served,
    output logic [LANES-1:0]                o_next_pending
);

    logic [LANES-1:0] w_taken;

    always_comb begin
        o_winner_valid = '0;
        o_winner       = '0;
        o_served       = '0;
        w_taken        = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_pending[l] && i_lane_bank[l] == BANK_W'(b) && !o_winner_valid[b]) begin
                    o_winner_valid[b] = 1'b1;
                    o_winner[b]       = LANE_W'(l);
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (o_winner_valid[b] && i_pending[l] && i_lane_bank[l] == BANK_W'(b)) begin
                    if (i_is_store)
                        o_served[b][l] = (o_winner[b] == LANE_W'(l));
                    else
                        o_served[b][l] = (i_lane_offset[l] == i_lane_offset[o_winner[b]]);
                end
            end
            w_taken = w_taken | o_served[b];
        end
        o_next_pending = i_pending & ~w_taken;
    end

endmodule

// File: rtl/spm_bank_request_serializer.sv
// Serializes one vector scratchpad request onto the bank ports, one access per bank per
// cycle, and gathers the synchronous read data back into lane order for a single response.
module spm_bank_request_serializer
    import npu_spm_defines::*;
#(
    parameter int LANES      = SM_PROCESSING_ELEMENTS,
    parameter int BANKS      = SM_MEMORY_BANKS,
    parameter int ENTRIES    = SM_ENTRIES,
    parameter int DATA_WIDTH = SM_DATA_WIDTH,
    parameter int BANK_W     = $clog2(BANKS),
    parameter int OFFSET_W   = $clog2(ENTRIES),
    parameter int ADDR_W     = BANK_W + OFFSET_W,
    parameter int BYTES      = DATA_WIDTH / 8,
    parameter int LANE_W     = $clog2(LANES)
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // valid never waits on ready, and the response payload holds until it is taken.
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_is_store,
    input  logic [LANES-1:0]                     req_lane_mask,
    input  logic [LANES-1:0][ADDR_W-1:0]         req_address,
    input  logic [LANES-1:0][BYTES-1:0]          req_byte_mask,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     req_write_data,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     resp_read_data,
    output logic [BANKS-1:0]                     bank_enables,
    output logic                                 bank_is_store,
    output logic [BANKS-1:0][OFFSET_W-1:0]       bank_offsets,
    output logic [BANKS-1:0][BYTES-1:0]          bank_byte_mask,
    output logic [BANKS-1:0][DATA_WIDTH-1:0]     bank_write_data,
    input  logic [BANKS-1:0][DATA_WIDTH-1:0]     bank_read_data,
    output logic [1:0]                           dbg_state
);

    logic [1:0]                          r_state;
    logic                                r_is_store;
    logic [LANES-1:0]                    r_pending;
    logic [LANES-1:0][ADDR_W-1:0]        r_address;
    logic [LANES-1:0][BYTES-1:0]         r_byte_mask;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_write_data;
    logic [BANKS-1:0][LANES-1:0]         r_served_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_result;

    logic [LANES-1:0][BANK_W-1:0]        w_lane_bank;
    logic [LANES-1:0][OFFSET_W-1:0]      w_lane_offset;
    logic [BANKS-1:0]                    w_winner_valid;
    logic [BANKS-1:0][LANE_W-1:0]        w_winner;
    logic [BANKS-1:0][LANES-1:0]         w_served;
    logic [LANES-1:0]                    w_next_pending;
    logic                                w_issue;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_bank[l]   = r_address[l][BANK_W-1:0];
            w_lane_offset[l] = r_address[l][ADDR_W-1:BANK_W];
        end
    end

    spm_bank_arbiter #(
        .LANES    (LANES),
        .BANKS    (BANKS),
        .OFFSET_W (OFFSET_W),
        .BANK_W   (BANK_W),
        .LANE_W   (LANE_W)
    ) u_arbiter (
        .i_pending      (r_pending),
        .i_lane_bank    (w_lane_bank),
        .i_lane_offset  (w_lane_offset),
        .i_is_store     (r_is_store),
        .o_winner_valid (w_winner_valid),
        .o_winner       (w_winner),
        .o_served       (w_served),
        .o_next_pending (w_next_pending)
    );

    assign w_issue        = (r_state == SPM_ISSUE);
    assign req_ready      = (r_state == SPM_IDLE);
    assign resp_valid     = (r_state == SPM_RESP);
    assign resp_read_data = r_result;
    assign bank_is_store  = w_issue & r_is_store;
    assign dbg_state      = r_state;

    // Bank drive is decoded from state so an asynchronous reset drops enables at once.
    always_comb begin
        bank_enables    = '0;
        bank_offsets    = '0;
        bank_byte_mask  = '0;
        bank_write_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_issue && w_winner_valid[b]) begin
                bank_enables[b]    = 1'b1;
                bank_offsets[b]    = w_lane_offset[w_winner[b]];
                bank_byte_mask[b]  = r_is_store ? r_byte_mask[w_winner[b]] : '0;
                bank_write_data[b] = r_write_data[w_winner[b]];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= SPM_IDLE;
            r_is_store   <= 1'b0;
            r_pending    <= '0;
            r_address    <= '0;
            r_byte_mask  <= '0;
            r_write_data <= '0;
            r_served_q   <= '0;
            r_result     <= '0;
        end else begin
            r_served_q <= '0;
            // Read data for last cycle's issue lands now, overlapping the next issue.
            for (int b = 0; b < BANKS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (r_served_q[b][l])
                        r_result[l] <= bank_read_data[b];
                end
            end
            case (r_state)
                SPM_IDLE: begin
                    if (req_valid) begin
                        r_is_store   <= req_is_store;
                        r_pending    <= req_lane_mask;
                        r_address    <= req_address;
                        r_byte_mask  <= req_byte_mask;
                        r_write_data <= req_write_data;
                        r_result     <= '0;
                        r_state      <= (req_lane_mask == '0) ? SPM_RESP : SPM_ISSUE;
                    end
                end
                SPM_ISSUE: begin
                    r_pending <= w_next_pending;
                    if (!r_is_store)
                        r_served_q <= w_served;
                    if (w_next_pending == '0)
                        r_state <= r_is_store ? SPM_RESP : SPM_DRAIN;
                end
                SPM_DRAIN: r_state <= SPM_RESP;
                SPM_RESP: begin
                    if (resp_ready)
                        r_state <= SPM_IDLE;
                end
                default: r_state <= SPM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_bank_request_serializer.sv
// Directed bench for spm_bank_request_serializer with a behavioural banked memory behind it.
module tb_spm_bank_request_serializer;

    localparam int LANES   = 16;
    localparam int BANKS   = 16;
    localparam int ENTRIES = 1024;
    localparam int DW      = 32;
    localparam int OW      = 10;
    localparam int AW      = 14;
    localparam int BY      = 4;

    logic                           clock = 1'b0;
    logic                           resetn;
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_is_store;
    logic [LANES-1:0]               req_lane_mask;
    logic [LANES-1:0][AW-1:0]       req_address;
    logic [LANES-1:0][BY-1:0]       req_byte_mask;
    logic [LANES-1:0][DW-1:0]       req_write_data;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [LANES-1:0][DW-1:0]       resp_read_data;
    logic [BANKS-1:0]               bank_enables;
    logic                           bank_is_store;
    logic [BANKS-1:0][OW-1:0]       bank_offsets;
    logic [BANKS-1:0][BY-1:0]       bank_byte_mask;
    logic [BANKS-1:0][DW-1:0]       bank_write_data;
    logic [BANKS-1:0][DW-1:0]       bank_read_data;
    logic [1:0]                     dbg_state;

    logic [DW-1:0]                  mem [BANKS][ENTRIES];
    logic [LANES*DW-1:0]            exp_q[$];
    int                             n_checks = 0;
    int                             n_pass   = 0;
    int                             cyc      = 0;
    int                             acc_cyc  = 0;

    spm_bank_request_serializer dut (
        .clock           (clock),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_lane_mask   (req_lane_mask),
        .req_address     (req_address),
        .req_byte_mask   (req_byte_mask),
        .req_write_data  (req_write_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_read_data  (resp_read_data),
        .bank_enables    (bank_enables),
        .bank_is_store   (bank_is_store),
        .bank_offsets    (bank_offsets),
        .bank_byte_mask  (bank_byte_mask),
        .bank_write_data (bank_write_data),
        .bank_read_data  (bank_read_data),
        .dbg_state       (dbg_state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Banked memory: one-cycle read latency, byte-masked writes, preloaded with 0x100+address.
    always @(posedge clock) begin
        if (!resetn) begin
            for (int b = 0; b < BANKS; b++)
                for (int o = 0; o < ENTRIES; o++)
                    mem[b][o] <= 32'h100 + 32'(o * BANKS + b);
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_enables[b]) begin
                    bank_read_data[b] <= mem[b][bank_offsets[b]];
                    if (bank_is_store)
                        for (int k = 0; k < BY; k++)
                            if (bank_byte_mask[b][k])
                                mem[b][bank_offsets[b]][8*k +: 8] <= bank_write_data[b][8*k +: 8];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [LANES*DW-1:0] obs,
                            input logic [LANES*DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one request; returns at the negedge of the first cycle after the accept edge.
    task automatic send(input logic is_store, input logic [LANES-1:0] mask,
                        input logic [LANES-1:0][AW-1:0] addr,
                        input logic [LANES-1:0][BY-1:0] bm,
                        input logic [LANES-1:0][DW-1:0] wd);
        @(negedge clock);
        check_eq("req_ready_before_send", 512'(req_ready), 512'(1));
        req_is_store   = is_store;
        req_lane_mask  = mask;
        req_address    = addr;
        req_byte_mask  = bm;
        req_write_data = wd;
        req_valid      = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
        @(negedge clock);
    endtask

    // Wait for the response, check latency and data, hold it for `hold` cycles, then take it.
    task automatic wait_resp(input string tag, input int exp_lat, input int hold);
        logic [LANES*DW-1:0] exp;
        while (!resp_valid && (cyc - acc_cyc) < 40) @(negedge clock);
        check_eq({tag, "_latency"}, 512'(cyc - acc_cyc + 1), 512'(exp_lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_eq({tag, "_data"}, resp_read_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check_eq({tag, "_hold_valid"}, 512'(resp_valid), 512'(1));
            check_eq({tag, "_hold_req_ready"}, 512'(req_ready), 512'(0));
            check_eq({tag, "_hold_data"}, resp_read_data, exp);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        @(negedge clock);
        check_eq({tag, "_after_valid"}, 512'(resp_valid), 512'(0));
        check_eq({tag, "_after_req_ready"}, 512'(req_ready), 512'(1));
    endtask

    logic [LANES-1:0][AW-1:0] a;
    logic [LANES-1:0][BY-1:0] m;
    logic [LANES-1:0][DW-1:0] d;
    logic [LANES-1:0][DW-1:0] e;

    initial begin
        resetn         = 1'b0;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_lane_mask  = '0;
        req_address    = '0;
        req_byte_mask  = '0;
        req_write_data = '0;
        resp_ready     = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_req_ready", 512'(req_ready), 512'(1));
        check_eq("rst_resp_valid", 512'(resp_valid), 512'(0));
        check_eq("rst_bank_enables", 512'(bank_enables), 512'(0));
        check_eq("rst_resp_data", resp_read_data, '0);
        check_eq("rst_state", 512'(dbg_state), 512'(0));
        resetn = 1'b1;

        // 1: conflict-free load
        m = '0; d = '0;
        for (int i = 0; i < LANES; i++) begin a[i] = AW'(i); e[i] = 32'h100 + 32'(i); end
        exp_q.push_back(e);
        send(1'b0, 16'hFFFF, a, m, d);
        check_eq("s1_enables", 512'(bank_enables), 512'(16'hFFFF));
        check_eq("s1_offsets", 512'(bank_offsets), '0);
        check_eq("s1_is_store", 512'(bank_is_store), 512'(0));
        wait_resp("s1", 3, 0);

        // 2: full conflict on bank 3
        for (int i = 0; i < LANES; i++) begin a[i] = AW'(16 * i + 3); e[i] = 32'h103 + 32'(16 * i); end
        exp_q.push_back(e);
        send(1'b0, 16'hFFFF, a, m, d);
        for (int i = 0; i < LANES; i++) begin
            check_eq("s2_enables", 512'(bank_enables), 512'(16'h0008));
            check_eq("s2_offset", 512'(bank_offsets[3]), 512'(i));
            @(negedge clock);
        end
        wait_resp("s2", 18, 0);

        // 3: broadcast load of address 37 (bank 5, offset 2)
        for (int i = 0; i < LANES; i++) begin a[i] = AW'(37); e[i] = 32'h125; end
        exp_q.push_back(e);
        send(1'b0, 16'hFFFF, a, m, d);
        check_eq("s3_enables", 512'(bank_enables), 512'(16'h0020));
        check_eq("s3_offset", 512'(bank_offsets[5]), 512'(2));
        wait_resp("s3", 3, 0);

        // 4: same-address stores from lanes 2 and 9, then read back
        for (int i = 0; i < LANES; i++) begin a[i] = AW'(4); m[i] = 4'hF; d[i] = '0; end
        d[2] = 32'hAAAAAAAA;
        d[9] = 32'hBBBBBBBB;
        exp_q.push_back('0);
        send(1'b1, 16'h0204, a, m, d);
        check_eq("s4_enables_a", 512'(bank_enables), 512'(16'h0010));
        check_eq("s4_is_store", 512'(bank_is_store), 512'(1));
        check_eq("s4_wdata_a", 512'(bank_write_data[4]), 512'(32'hAAAAAAAA));
        check_eq("s4_bmask_a", 512'(bank_byte_mask[4]), 512'(4'hF));
        @(negedge clock);
        check_eq("s4_enables_b", 512'(bank_enables), 512'(16'h0010));
        check_eq("s4_wdata_b", 512'(bank_write_data[4]), 512'(32'hBBBBBBBB));
        wait_resp("s4", 3, 0);
        m = '0; d = '0; e = '0;
        e[0] = 32'hBBBBBBBB;
        exp_q.push_back(e);
        send(1'b0, 16'h0001, a, m, d);
        check_eq("s4_load_bmask", 512'(bank_byte_mask[4]), 512'(0));
        wait_resp("s4_readback", 3, 0);

        // 5: backpressure on a single-lane load, then an empty mask
        e = '0;
        a[5] = AW'(5);
        e[5] = 32'h105;
        exp_q.push_back(e);
        send(1'b0, 16'h0020, a, m, d);
        wait_resp("s5_hold", 3, 5);
        exp_q.push_back('0);
        send(1'b0, 16'h0000, a, m, d);
        check_eq("s5_empty_enables", 512'(bank_enables), 512'(0));
        wait_resp("s5_empty", 1, 0);

        // 6: reset in the middle of a full-conflict load
        for (int i = 0; i < LANES; i++) a[i] = AW'(16 * i + 3);
        send(1'b0, 16'hFFFF, a, m, d);
        for (int i = 0; i < 4; i++) begin
            check_eq("s6_enables", 512'(bank_enables), 512'(16'h0008));
            @(negedge clock);
        end
        resetn = 1'b0;
        #1;
        check_eq("s6_rst_enables", 512'(bank_enables), 512'(0));
        check_eq("s6_rst_req_ready", 512'(req_ready), 512'(1));
        check_eq("s6_rst_resp_valid", 512'(resp_valid), 512'(0));
        check_eq("s6_rst_is_store", 512'(bank_is_store), 512'(0));
        check_eq("s6_rst_data", resp_read_data, '0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("s6_no_resp", 512'(resp_valid), 512'(0));
            check_eq("s6_req_ready", 512'(req_ready), 512'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
